// File: rtl/obi_pkg.sv
// Minimal OBI configuration and channel types
// used by the user-domain OBI managers.
package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: 32,
        DataWidth: 32,
        IdWidth:   1
    };

    localparam int unsigned Aw = ObiDefaultConfig.AddrWidth;
    localparam int unsigned Dw = ObiDefaultConfig.DataWidth;
    localparam int unsigned Iw = ObiDefaultConfig.IdWidth;

    typedef struct packed {
        logic [Aw-1:0]   addr;
        logic            we;
        logic [Dw/8-1:0] be;
        logic [Dw-1:0]   wdata;
        logic [Iw-1:0]   aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [Dw-1:0] rdata;
        logic [Iw-1:0] rid;
        logic          err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

// File: rtl/user_obi_window_fetcher.sv
// OBI read manager: fetches a WinDim x WinDim pixel window with up to
// MaxOutstanding pipelined reads and presents it on a valid/ready stream.
// Ports: clk_i, rst_ni (async, active low); obi_req_o / obi_rsp_i (OBI
// manager); start_i, base_addr_i, stride_i (control); win_valid_o,
// win_ready_i, win_data_o (window stream); busy_o, err_o, done_o (status).
module user_obi_window_fetcher #(
    parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
    parameter type obi_req_t = obi_pkg::obi_req_t,
    parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned WinDim = 3,
    parameter int unsigned PixWidth = 8,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    output obi_req_t                           obi_req_o,
    input  obi_rsp_t                           obi_rsp_i,
    input  logic                               start_i,
    input  logic [ObiCfg.AddrWidth-1:0]        base_addr_i,
    input  logic [ObiCfg.AddrWidth-1:0]        stride_i,
    output logic                               win_valid_o,
    input  logic                               win_ready_i,
    output logic [WinDim*WinDim*PixWidth-1:0]  win_data_o,
    output logic                               busy_o,
    output logic                               err_o,
    output logic                               done_o
);

    localparam int unsigned AW = ObiCfg.AddrWidth;
    localparam int unsigned NumPix = WinDim * WinDim;
    localparam int unsigned CntW = $clog2(NumPix + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
    localparam int unsigned ColW = (WinDim > 1) ? $clog2(WinDim) : 1;

    localparam logic [CntW-1:0] NumPixC = CntW'(NumPix);
    localparam logic [CntW-1:0] LastC = CntW'(NumPix - 1);
    localparam logic [OutW-1:0] MaxOutC = OutW'(MaxOutstanding);
    localparam logic [ColW-1:0] LastCol = ColW'(WinDim - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   row_q;
    logic [AW-1:0]   stride_q;
    logic [ColW-1:0] col_q;
    logic [CntW-1:0] issue_cnt_q;
    logic [CntW-1:0] rsp_cnt_q;
    logic [OutW-1:0] outst_q;
    logic            err_q;
    logic [NumPix*PixWidth-1:0] win_q;

    logic req;
    logic issue_hs;
    logic rsp_hs;
    logic last_issue;
    logic last_rsp;
    logic launch;

    // The issue condition only looks at registered counts, so once req is
    // high it can only stay high: outstanding can drop but never rise
    // without a grant, and addr_q moves only on a grant.
    assign req = (state_q == FETCH)
              && (issue_cnt_q < NumPixC)
              && (outst_q < MaxOutC);

    assign issue_hs = req && obi_rsp_i.gnt;

    // A response with nothing outstanding is stray and must not touch slots.
    assign rsp_hs = obi_rsp_i.rvalid
                 && (outst_q != '0)
                 && (rsp_cnt_q < NumPixC);

    assign last_issue = (issue_cnt_q == LastC);
    assign last_rsp = (rsp_cnt_q == LastC);
    assign launch = (state_q == IDLE) && start_i;

    always_comb begin
        state_d = state_q;
        done_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = FETCH;
            end
            FETCH: begin
                if (issue_hs && last_issue) begin
                    state_d = (rsp_hs && last_rsp) ? OUT : WAIT;
                end
            end
            WAIT: begin
                if (rsp_hs && last_rsp) state_d = OUT;
            end
            OUT: begin
                if (win_ready_i) begin
                    state_d = IDLE;
                    done_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            row_q       <= '0;
            stride_q    <= '0;
            col_q       <= '0;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
            win_q       <= '0;
        end else if (launch) begin
            addr_q      <= base_addr_i;
            row_q       <= base_addr_i;
            stride_q    <= stride_i;
            col_q       <= '0;
            issue_cnt_q <= '0;
            rsp_cnt_q   <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (issue_hs) begin
                issue_cnt_q <= issue_cnt_q + CntW'(1);
                // Walk the window incrementally; wraps modulo 2^AW.
                if (col_q == LastCol) begin
                    col_q  <= '0;
                    row_q  <= row_q + stride_q;
                    addr_q <= row_q + stride_q;
                end else begin
                    col_q  <= col_q + ColW'(1);
                    addr_q <= addr_q + AW'(4);
                end
            end
            if (rsp_hs) begin
                rsp_cnt_q <= rsp_cnt_q + CntW'(1);
                win_q[rsp_cnt_q*PixWidth +: PixWidth] <=
                    obi_rsp_i.r.rdata[PixWidth-1:0];
                if (obi_rsp_i.r.err) err_q <= 1'b1;
            end
            if (issue_hs && !rsp_hs) begin
                outst_q <= outst_q + OutW'(1);
            end else if (!issue_hs && rsp_hs) begin
                outst_q <= outst_q - OutW'(1);
            end
        end
    end

    always_comb begin
        obi_req_o = '0;
        obi_req_o.req = req;
        obi_req_o.a.addr = addr_q;
        obi_req_o.a.we = 1'b0;
        obi_req_o.a.be = '1;
        obi_req_o.a.wdata = '0;
        obi_req_o.a.aid = '0;
    end

    assign win_valid_o = (state_q == OUT);
    assign win_data_o  = win_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;

    logic unused_rsp;
    assign unused_rsp = ^{obi_rsp_i.r.rdata, obi_rsp_i.r.rid};

    stray_rvalid: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        obi_rsp_i.rvalid |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_user_obi_window_fetcher.sv
// Directed bench for user_obi_window_fetcher with an SRAM model that
// returns rdata = addr and can stall grants, hold responses and flag errors.
module tb_user_obi_window_fetcher;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    obi_pkg::obi_req_t req;
    obi_pkg::obi_rsp_t rsp;

    logic        start;
    logic [31:0] base;
    logic [31:0] stride;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic        busy;
    logic        err;
    logic        done;

    user_obi_window_fetcher dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .obi_req_o   (req),
        .obi_rsp_i   (rsp),
        .start_i     (start),
        .base_addr_i (base),
        .stride_i    (stride),
        .win_valid_o (win_valid),
        .win_ready_i (win_ready),
        .win_data_o  (win_data),
        .busy_o      (busy),
        .err_o       (err),
        .done_o      (done)
    );

    int n_assert = 0;
    int n_fail = 0;

    int stall_at = -1;
    int err_at = -1;
    int budget = 1 << 30;

    int gnt_total = 0;
    int popped = 0;
    int stall_wait = 0;
    int stall_cycles = 0;
    int stall_viol = 0;
    int tb_outst = 0;
    int max_outst = 0;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [31:0] addr_log [256];

    typedef struct packed {
        logic [31:0] a;
        logic        e;
    } pend_t;
    pend_t pq[$];

    logic        rv_q;
    logic [31:0] rd_q;
    logic        re_q;
    logic        gnt;

    always_comb begin
        gnt = req.req && ((gnt_total != stall_at) || (stall_wait >= 3));
        rsp = '0;
        rsp.gnt = gnt;
        rsp.rvalid = rv_q;
        rsp.r.rdata = rd_q;
        rsp.r.err = re_q;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq.delete();
            rv_q <= 1'b0;
            rd_q <= '0;
            re_q <= 1'b0;
            tb_outst <= 0;
            stall_wait <= 0;
            prev_stall <= 1'b0;
            prev_addr <= '0;
        end else begin
            if (req.req && gnt) begin
                pq.push_back(pend_t'{a: req.a.addr, e: (gnt_total == err_at)});
                addr_log[gnt_total[7:0]] <= req.a.addr;
                gnt_total <= gnt_total + 1;
                stall_wait <= 0;
            end else if (req.req) begin
                stall_wait <= stall_wait + 1;
                stall_cycles <= stall_cycles + 1;
            end
            if (pq.size() > 0 && popped < budget) begin
                rv_q <= 1'b1;
                rd_q <= pq[0].a;
                re_q <= pq[0].e;
                void'(pq.pop_front());
                popped <= popped + 1;
            end else begin
                rv_q <= 1'b0;
            end
            tb_outst <= tb_outst + int'(req.req && gnt) - int'(rv_q);
            if (tb_outst > max_outst) max_outst <= tb_outst;
            if (prev_stall && !(req.req && req.a.addr == prev_addr)) begin
                stall_viol <= stall_viol + 1;
            end
            prev_stall <= req.req && !gnt;
            prev_addr <= req.a.addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 100 && win_valid !== 1'b1; i++) step();
        chk({tag, "_valid"}, 72'(win_valid), 72'd1);
    endtask

    task automatic handshake(input string tag);
        win_ready = 1'b1;
        #1;
        chk({tag, "_done"}, 72'(done), 72'd1);
        step();
        win_ready = 1'b0;
        chk({tag, "_idle"}, 72'(busy), 72'd0);
        chk({tag, "_done_low"}, 72'(done), 72'd0);
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] s);
        base = b;
        stride = s;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    localparam logic [71:0] WinA = 72'h88_84_80_48_44_40_08_04_00;
    localparam logic [71:0] WinErr = 72'h48_44_40_28_24_20_08_04_00;
    localparam logic [71:0] WinWrap = 72'h08_04_00_04_00_FC_00_FC_F8;
    localparam logic [71:0] WinRst = 72'h28_24_20_18_14_10_08_04_00;

    logic [31:0] t1_addr [9] = '{
        32'h1000_0000, 32'h1000_0004, 32'h1000_0008,
        32'h1000_0040, 32'h1000_0044, 32'h1000_0048,
        32'h1000_0080, 32'h1000_0084, 32'h1000_0088
    };
    logic [31:0] wrap_addr [9] = '{
        32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000,
        32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004,
        32'h0000_0000, 32'h0000_0004, 32'h0000_0008
    };

    int g0;
    int s0;

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        win_ready = 1'b0;
        base = '0;
        stride = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", 72'(req.req), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_valid", 72'(win_valid), 72'd0);
        chk("rst_done", 72'(done), 72'd0);
        chk("rst_err", 72'(err), 72'd0);
        chk("rst_data", win_data, 72'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Zero-wait fetch: latency, addresses, data, done pulse
        g0 = gnt_total;
        pulse_start(32'h1000_0000, 32'h40);
        chk("t1_req_c1", 72'(req.req), 72'd1);
        chk("t1_addr_c1", 72'(req.a.addr), 72'h1000_0000);
        chk("t1_busy", 72'(busy), 72'd1);
        repeat (9) step();
        chk("t1_valid_c10", 72'(win_valid), 72'd0);
        step();
        chk("t1_valid_c11", 72'(win_valid), 72'd1);
        chk("t1_data", win_data, WinA);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t1_addr%0d", i), 72'(addr_log[(g0 + i) % 256]),
                72'(t1_addr[i]));
        end
        handshake("t1");

        // Held responses throttle issue; read 4 grant stalled 3 cycles
        g0 = gnt_total;
        s0 = stall_cycles;
        stall_at = gnt_total + 3;
        budget = popped;
        pulse_start(32'h1000_0000, 32'h40);
        repeat (5) step();
        chk("t2_throttle_req", 72'(req.req), 72'd0);
        chk("t2_outst", 72'(tb_outst), 72'd2);
        budget = popped + 1000;
        wait_valid("t2");
        chk("t2_stall_cycles", 72'(stall_cycles - s0), 72'd3);
        chk("t2_stable", 72'(stall_viol), 72'd0);
        chk("t2_max_outst", 72'(max_outst), 72'd2);
        chk("t2_data", win_data, WinA);
        stall_at = -1;

        // Consumer back-pressure with stray start pulses
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            step();
            chk($sformatf("t3_valid%0d", i), 72'(win_valid), 72'd1);
            chk($sformatf("t3_data%0d", i), win_data, WinA);
            chk($sformatf("t3_busy%0d", i), 72'(busy), 72'd1);
        end
        start = 1'b0;
        handshake("t3");
        step();
        chk("t3_no_refetch", 72'(busy), 72'd0);
        chk("t3_no_req", 72'(req.req), 72'd0);

        // Error on read 6: sticky, all reads still issued
        g0 = gnt_total;
        err_at = gnt_total + 5;
        pulse_start(32'h0000_0300, 32'h20);
        chk("t4_err_clear", 72'(err), 72'd0);
        wait_valid("t4");
        chk("t4_err", 72'(err), 72'd1);
        chk("t4_reads", 72'(gnt_total - g0), 72'd9);
        chk("t4_data", win_data, WinErr);
        handshake("t4");
        chk("t4_err_hold", 72'(err), 72'd1);
        err_at = -1;

        // Address wrap; new start clears err
        g0 = gnt_total;
        pulse_start(32'hFFFF_FFF8, 32'h4);
        chk("t5_err_cleared", 72'(err), 72'd0);
        wait_valid("t5");
        chk("t5_data", win_data, WinWrap);
        chk("t5_err", 72'(err), 72'd0);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t5_addr%0d", i), 72'(addr_log[(g0 + i) % 256]),
                72'(wrap_addr[i]));
        end
        handshake("t5");

        // Reset while waiting on 2 outstanding reads
        g0 = gnt_total;
        budget = popped + 7;
        pulse_start(32'h2000_0100, 32'h10);
        repeat (20) step();
        chk("t6_busy", 72'(busy), 72'd1);
        chk("t6_all_issued", 72'(gnt_total - g0), 72'd9);
        chk("t6_outst", 72'(tb_outst), 72'd2);
        chk("t6_valid", 72'(win_valid), 72'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 72'(req.req), 72'd0);
        chk("t6_rst_busy", 72'(busy), 72'd0);
        chk("t6_rst_valid", 72'(win_valid), 72'd0);
        chk("t6_rst_data", win_data, 72'd0);
        chk("t6_rst_err", 72'(err), 72'd0);
        chk("t6_rst_done", 72'(done), 72'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        budget = popped + 1000;
        step();
        pulse_start(32'h2000_0100, 32'h10);
        wait_valid("t6");
        chk("t6_data", win_data, WinRst);
        chk("t6_err", 72'(err), 72'd0);
        handshake("t6");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/user_obi_window_fetcher.md
Name: user_obi_window_fetcher

Overview:
- OBI manager that fetches a WinDim x WinDim pixel window from SRAM0 for the Sobel datapath.
- Parametrised in window size, pixel width and number of outstanding reads; issues pipelined reads instead of one at a time.
- Assembled window is presented on a valid/ready stream.
- Sits in the user domain between a control register block (start/base/stride) and the filter core.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration (AddrWidth, DataWidth=32, IdWidth).
- obi_req_t, logic, OBI request struct.
- obi_rsp_t, logic, OBI response struct.
- WinDim, 3, window side length; NumPix = WinDim*WinDim (>=1).
- PixWidth, 8, pixel bits taken from rdata[PixWidth-1:0]; one pixel per 32-bit word.
- MaxOutstanding, 2, max issued-but-unanswered reads (1..4).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- obi_req_o  out  obi_req_t  OBI manager request (a.we=0, a.be='1, a.wdata=0, a.aid=0)
- obi_rsp_i  in  obi_rsp_t  OBI response (gnt, rvalid, r.rdata, r.err)
- start_i  in  1  one-cycle pulse; sampled only in IDLE
- base_addr_i  in  ObiCfg.AddrWidth  byte address of window top-left pixel, word aligned
- stride_i  in  ObiCfg.AddrWidth  byte distance between rows
- win_valid_o  out  1  window available
- win_ready_i  in  1  consumer accepts window
- win_data_o  out  NumPix*PixWidth  pixel k (k = r*WinDim+c) at bits [k*PixWidth +: PixWidth]
- busy_o  out  1  high whenever state != IDLE
- err_o  out  1  sticky: any response in current window had r.err=1
- done_o  out  1  one-cycle pulse on window handshake

Behaviour:
- Reset: all outputs 0, obi_req_o.req=0, state IDLE, counters 0, window register 0.
- States: IDLE, FETCH, WAIT, OUT.
- IDLE -> FETCH on start_i. Latch base/stride, clear err_o, issue_cnt and rsp_cnt. start_i outside IDLE is ignored.
- Address for read k: base + r*stride + c*4, computed incrementally (column +4, row-start +stride), modulo 2^AddrWidth (wrap, no error).
- Request rules:
  - req asserted when issue_cnt<NumPix and outstanding<MaxOutstanding.
  - Once req=1, addr and req stay stable until gnt (OBI rule); req is never withdrawn without gnt.
  - Handshake when req&&gnt: issue_cnt++, outstanding++.
- Responses are in order. On rvalid: store rdata[PixWidth-1:0] in slot rsp_cnt, rsp_cnt++, outstanding--. If r.err, set err_o; the data is still stored.
- Same-cycle gnt and rvalid: outstanding unchanged. This allows back-to-back issue at outstanding=MaxOutstanding when a response retires in that cycle? No: the issue condition uses the registered count, so no issue occurs then.
- FETCH -> WAIT when the last grant occurs (issue_cnt reaches NumPix).
- WAIT -> OUT when the last response arrives. If the final grant and final rvalid coincide (MaxOutstanding=1 impossible, else allowed), go directly to OUT when rsp_cnt completes.
- rvalid while no read is outstanding is ignored (must not corrupt slots); assertion in sim.
- OUT:
  - win_valid_o=1; win_data_o is stable until win_ready_i.
  - On the handshake: done_o pulses, go to IDLE. err_o holds until the next start.
- Latency, zero-wait memory (gnt same cycle, rvalid next cycle), MaxOutstanding>=2:
  - start at cycle 0 -> req cycles 1..NumPix -> last rvalid cycle NumPix+1 -> win_valid_o cycle NumPix+2.
  - With MaxOutstanding=1, one read every 2 cycles.
- Reset mid-operation: immediate return to IDLE, req dropped. In-flight responses after reset are the interconnect's concern.

Test Plan:
- Zero-wait SRAM, base=0x1000_0000, stride=0x40, WinDim=3, SRAM word at addr = addr[7:0]:
  - 9 reads at 0x..00, 04, 08, 40, 44, 48, 80, 84, 88.
  - win_data_o bytes = {88,84,80,48,44,40,08,04,00} (MSB first).
  - win_valid_o at cycle 11, done_o on the ready cycle.
- gnt delayed 3 cycles on read 4 -> addr/req stable for all 4 cycles. Issue is throttled so outstanding never exceeds 2 (monitor check). Window is correct.
- win_ready_i low for 5 cycles -> win_valid_o and win_data_o held constant. start_i pulses during OUT are ignored, and busy_o stays 1.
- r.err=1 on read 6 -> err_o=1 at window completion, remaining reads still issued. The next start clears err_o.
- base=0xFFFF_FFF8, stride=4 -> addresses wrap to 0x0000_0000 etc., no hang.
- rst_ni asserted during WAIT with 2 reads outstanding -> all outputs 0 the same cycle. A subsequent start fetches a fresh, correct window.
